// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port among NUM_REQ writeback sources.
// The winning write is registered and fanned out as one-hot enables plus a bypass bus.
module regfile_write_arbiter #(
    parameter int NUM_REQ    = 3,
    parameter int NUM_REGS   = 32,
    parameter int REG_WIDTH  = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          hold,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*REG_WIDTH-1:0]  req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REGS-1:0]           wr_en,
    output logic [REG_WIDTH-1:0]          wr_data,
    output logic                          wb_valid,
    output logic [ADDR_WIDTH-1:0]         wb_addr,
    output logic [REG_WIDTH-1:0]          wb_data,
    output logic                          err_addr
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0]      rr_ptr_reg;
    logic [PTR_W-1:0]      rr_ptr_next;
    logic [2*NUM_REQ-1:0]  valid_rot;
    logic [PTR_W-1:0]      grant_off;
    logic [PTR_W:0]        grant_sum;
    logic [PTR_W-1:0]      grant_idx;
    logic                  grant_any;
    logic [NUM_REQ-1:0]    grant;

    logic [ADDR_WIDTH-1:0] addr_masked [NUM_REQ];
    logic [REG_WIDTH-1:0]  data_masked [NUM_REQ];
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [REG_WIDTH-1:0]  sel_data;
    logic                  addr_oob;
    logic                  addr_ok;
    logic [NUM_REGS-1:0]   wr_en_next;

    logic [NUM_REGS-1:0]   wr_en_reg;
    logic [REG_WIDTH-1:0]  wr_data_reg;
    logic                  wb_valid_reg;
    logic [ADDR_WIDTH-1:0] wb_addr_reg;
    logic                  err_addr_reg;

    // Rotate the request vector so the search always starts at offset 0 from rr_ptr.
    assign valid_rot = {req_valid, req_valid} >> rr_ptr_reg;

    always_comb begin
        grant_any = 1'b0;
        grant_off = '0;
        if (!hold) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (!grant_any && valid_rot[k]) begin
                    grant_any = 1'b1;
                    grant_off = PTR_W'(k);
                end
            end
        end
        grant_sum = {1'b0, rr_ptr_reg} + {1'b0, grant_off};
        if (grant_sum >= (PTR_W+1)'(NUM_REQ))
            grant_sum = grant_sum - (PTR_W+1)'(NUM_REQ);
        grant_idx = grant_sum[PTR_W-1:0];
    end

    always_comb begin
        rr_ptr_next = rr_ptr_reg;
        if (grant_any)
            rr_ptr_next = (grant_idx == PTR_W'(NUM_REQ-1)) ? '0 : grant_idx + PTR_W'(1);
    end

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign grant[gi]       = grant_any && (grant_idx == PTR_W'(gi));
            assign addr_masked[gi] = grant[gi] ? req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH] : '0;
            assign data_masked[gi] = grant[gi] ? req_data[gi*REG_WIDTH +: REG_WIDTH] : '0;
        end
    endgenerate

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sel_addr = sel_addr | addr_masked[k];
            sel_data = sel_data | data_masked[k];
        end
    end

    assign addr_oob = (32'(sel_addr) >= 32'(NUM_REGS));
    assign addr_ok  = (sel_addr != '0) && !addr_oob;

    // Register 0 is grounded; out-of-range addresses never match an enable.
    assign wr_en_next[0] = 1'b0;
    generate
        for (genvar gi = 1; gi < NUM_REGS; gi++) begin : g_en
            assign wr_en_next[gi] = grant_any && (sel_addr == ADDR_WIDTH'(gi));
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_reg   <= '0;
            wr_en_reg    <= '0;
            wr_data_reg  <= '0;
            wb_valid_reg <= 1'b0;
            wb_addr_reg  <= '0;
            err_addr_reg <= 1'b0;
        end else begin
            rr_ptr_reg   <= rr_ptr_next;
            wr_en_reg    <= wr_en_next;
            wb_valid_reg <= grant_any && addr_ok;
            err_addr_reg <= grant_any && addr_oob;
            if (grant_any) begin
                wr_data_reg <= sel_data;
                wb_addr_reg <= sel_addr;
            end
        end
    end

    assign req_ready = grant;
    assign wr_en     = wr_en_reg;
    assign wr_data   = wr_data_reg;
    assign wb_data   = wr_data_reg;
    assign wb_valid  = wb_valid_reg;
    assign wb_addr   = wb_addr_reg;
    assign err_addr  = err_addr_reg;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed plus random checking of regfile_write_arbiter against a transaction-level model.
module tb_regfile_write_arbiter;

    localparam int NR    = 3;
    localparam int NREGS = 16;
    localparam int RW    = 32;
    localparam int AW    = 5;

    logic              clk       = 1'b0;
    logic              rst_n     = 1'b0;
    logic              hold      = 1'b0;
    logic [NR-1:0]     req_valid = '0;
    logic [NR*AW-1:0]  req_addr  = '0;
    logic [NR*RW-1:0]  req_data  = '0;
    logic [NR-1:0]     req_ready;
    logic [NREGS-1:0]  wr_en;
    logic [RW-1:0]     wr_data;
    logic              wb_valid;
    logic [AW-1:0]     wb_addr;
    logic [RW-1:0]     wb_data;
    logic              err_addr;

    regfile_write_arbiter #(
        .NUM_REQ   (NR),
        .NUM_REGS  (NREGS),
        .REG_WIDTH (RW),
        .ADDR_WIDTH(AW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .hold     (hold),
        .req_valid(req_valid),
        .req_addr (req_addr),
        .req_data (req_data),
        .req_ready(req_ready),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .wb_valid (wb_valid),
        .wb_addr  (wb_addr),
        .wb_data  (wb_data),
        .err_addr (err_addr)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state: pointer plus expected registered outputs.
    int               m_ptr      = 0;
    int               last_grant = -1;
    logic [NREGS-1:0] e_wr_en    = '0;
    logic [RW-1:0]    e_wr_data  = '0;
    logic             e_wb_valid = 1'b0;
    logic [AW-1:0]    e_wb_addr  = '0;
    logic             e_err      = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic v, input logic [AW-1:0] a, input logic [RW-1:0] d);
        req_valid[i]          = v;
        req_addr[i*AW +: AW]  = a;
        req_data[i*RW +: RW]  = d;
    endtask

    function automatic int model_pick();
        if (hold) return -1;
        for (int k = 0; k < NR; k++) begin
            int i;
            i = (m_ptr + k) % NR;
            if (req_valid[i]) return i;
        end
        return -1;
    endfunction

    task automatic check_outputs(input string tag);
        chk({tag, ".wr_en"},    64'(wr_en),    64'(e_wr_en));
        chk({tag, ".wr_data"},  64'(wr_data),  64'(e_wr_data));
        chk({tag, ".wb_data"},  64'(wb_data),  64'(e_wr_data));
        chk({tag, ".wb_valid"}, 64'(wb_valid), 64'(e_wb_valid));
        chk({tag, ".wb_addr"},  64'(wb_addr),  64'(e_wb_addr));
        chk({tag, ".err_addr"}, 64'(err_addr), 64'(e_err));
    endtask

    // Entered just after a rising edge with inputs already driven.
    task automatic do_cycle(input string tag);
        int            g;
        logic [NR-1:0] er;
        logic [AW-1:0] a;
        logic [RW-1:0] d;
        #2;
        g  = model_pick();
        er = '0;
        if (g >= 0) er[g] = 1'b1;
        chk({tag, ".ready"}, 64'(req_ready), 64'(er));
        @(posedge clk);
        last_grant = g;
        if (g >= 0) begin
            a          = req_addr[g*AW +: AW];
            d          = req_data[g*RW +: RW];
            e_wr_data  = d;
            e_wb_addr  = a;
            e_wb_valid = (int'(a) != 0) && (int'(a) < NREGS);
            e_wr_en    = e_wb_valid ? (NREGS'(1) << a) : '0;
            e_err      = (int'(a) >= NREGS);
            m_ptr      = (g + 1) % NR;
            $display("xfer %s req=%0d addr=%0d data=%08h", tag, g, a, d);
        end else begin
            e_wr_en    = '0;
            e_wb_valid = 1'b0;
            e_err      = 1'b0;
        end
        #1;
        check_outputs(tag);
    endtask

    initial begin
        // Reset and idle
        repeat (2) @(posedge clk);
        #1;
        check_outputs("in_reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        do_cycle("idle");

        // Single request from requester 1
        set_req(1, 1'b1, 5'd5, 32'hDEADBEEF);
        do_cycle("single");
        set_req(1, 1'b0, 5'd0, 32'h0);
        do_cycle("single_after");

        // Accepted write followed by an asynchronous reset half a cycle later
        set_req(1, 1'b1, 5'd7, 32'h12345678);
        do_cycle("rst_xfer");
        set_req(1, 1'b0, 5'd0, 32'h0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        m_ptr      = 0;
        e_wr_en    = '0;
        e_wr_data  = '0;
        e_wb_valid = 1'b0;
        e_wb_addr  = '0;
        e_err      = 1'b0;
        check_outputs("rst_async");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        do_cycle("post_rst0");
        do_cycle("post_rst1");

        // All requesters continuously valid
        set_req(0, 1'b1, 5'd1, 32'hA0A0A0A0);
        set_req(1, 1'b1, 5'd2, 32'hB1B1B1B1);
        set_req(2, 1'b1, 5'd3, 32'hC2C2C2C2);
        repeat (6) do_cycle("rr");
        for (int i = 0; i < NR; i++) set_req(i, 1'b0, 5'd0, 32'h0);
        do_cycle("rr_after");

        // Write to grounded register 0
        set_req(0, 1'b1, 5'd0, 32'hFFFFFFFF);
        do_cycle("addr0");
        set_req(0, 1'b0, 5'd0, 32'h0);
        do_cycle("addr0_after");

        // Out-of-range address
        set_req(0, 1'b1, 5'd20, 32'h55AA55AA);
        do_cycle("oob");
        set_req(0, 1'b0, 5'd0, 32'h0);
        do_cycle("oob_after");

        // Bring the pointer back to 0, then hold with requesters 0 and 2 valid
        set_req(2, 1'b1, 5'd9, 32'h99999999);
        do_cycle("prep");
        set_req(2, 1'b0, 5'd0, 32'h0);
        hold = 1'b1;
        set_req(0, 1'b1, 5'd4, 32'h44444444);
        set_req(2, 1'b1, 5'd6, 32'h66666666);
        repeat (3) do_cycle("hold");
        hold = 1'b0;
        do_cycle("hold_rel0");
        do_cycle("hold_rel1");
        for (int i = 0; i < NR; i++) set_req(i, 1'b0, 5'd0, 32'h0);
        do_cycle("hold_after");

        // Random traffic; requests stay stable until accepted, occasionally withdrawn
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NR; i++) begin
                if (!req_valid[i]) begin
                    if ($urandom_range(0, 2) == 0)
                        set_req(i, 1'b1, 5'($urandom_range(0, 31)), $urandom);
                end else if ($urandom_range(0, 15) == 0) begin
                    set_req(i, 1'b0, 5'd0, 32'h0);
                end
            end
            hold = ($urandom_range(0, 4) == 0);
            do_cycle("rand");
            if (last_grant >= 0) set_req(last_grant, 1'b0, 5'd0, 32'h0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the single register-file write port in the decode stage among NUM_REQ writeback sources (ALU, load unit, mul/div, etc.).
- Arbitrates round-robin using a valid/ready handshake on each source.
- Registers the winning write and drives one-hot per-register enables plus shared write data to the register instances of the register file.
- Publishes the in-flight write on a bypass bus for forwarding. Register 0 is hardwired zero and never receives an enable.

Parameters:
- NUM_REQ, 3, number of writeback requesters (>=1).
- NUM_REGS, 32, number of architectural registers (index 0 grounded).
- REG_WIDTH, 32, data width of each register.
- ADDR_WIDTH, 5, register address width (2**ADDR_WIDTH >= NUM_REGS).

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset, asynchronous, active-low.
- hold  input  1  when 1, no requester is granted this cycle.
- req_valid  input  NUM_REQ  per-requester write request.
- req_addr  input  NUM_REQ*ADDR_WIDTH  packed destination addresses, requester i at bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_data  input  NUM_REQ*REG_WIDTH  packed write data, same packing.
- req_ready  output  NUM_REQ  grant/accept, at most one bit set.
- wr_en  output  NUM_REGS  one-hot enable to register instances; bit 0 always 0.
- wr_data  output  REG_WIDTH  data to all register instances.
- wb_valid  output  1  bypass bus valid.
- wb_addr  output  ADDR_WIDTH  bypass destination address.
- wb_data  output  REG_WIDTH  bypass data, equal to wr_data.
- err_addr  output  1  one-cycle pulse: an accepted write had addr >= NUM_REGS.

Behaviour:
- Reset (async assert, sync release): wr_en=0, wr_data=0, wb_valid=0, wb_addr=0, wb_data=0, err_addr=0, rr_ptr=0. Asserting reset mid-operation discards the in-flight stage; no enable is emitted after release until a new grant.
- req_ready is combinational from req_valid, hold and rr_ptr. A transfer on requester i occurs when req_valid[i] & req_ready[i]. Requesters hold valid/addr/data stable until accepted. Dropping valid before acceptance is allowed and is not an error.
- Arbitration:
  - If hold=1 or no valid request, req_ready=0 and rr_ptr is unchanged.
  - Otherwise, grant the first valid index scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - After a grant to i, rr_ptr <= (i+1) mod NUM_REQ.
  - NUM_REQ=1 degenerates to ready = valid & ~hold.
- Latency is 1 cycle. A transfer in cycle N produces outputs in cycle N+1:
  - addr in 1..NUM_REGS-1: wr_en = one-hot(addr), wr_data = wb_data = data, wb_addr = addr, wb_valid = 1, err_addr = 0.
  - addr == 0: accepted; wr_en = 0, wb_valid = 0, err_addr = 0; wr_data/wb_data/wb_addr are updated anyway.
  - addr >= NUM_REGS: accepted; wr_en = 0, wb_valid = 0, err_addr = 1 for exactly one cycle.
- No transfer in cycle N: wr_en = 0, wb_valid = 0, err_addr = 0 in N+1; wr_data, wb_data and wb_addr hold their previous values.
- Back-to-back transfers sustain one write per cycle. Consecutive writes to the same address are emitted in grant order; the later write wins in the register file.
- Simultaneous requests to the same address from different requesters are serialized in round-robin order. No merging or dropping.
- Fairness: a continuously valid requester is granted within NUM_REQ cycles of hold=0 cycles.

Test Plan:
- Reset then idle: all outputs 0, req_ready=0. Single request i=1, addr=5, data=0xDEADBEEF with hold=0 -> req_ready=3'b010 the same cycle; next cycle wr_en=1<<5, wr_data=0xDEADBEEF, wb_valid=1, wb_addr=5; the cycle after, wr_en=0.
- All 3 requesters continuously valid (addrs 1,2,3) for 6 cycles -> grant order 0,1,2,0,1,2; wr_en sequence 0x2,0x4,0x8,0x2,0x4,0x8, one per cycle.
- Requester 0 writes addr=0, data=0xFFFFFFFF -> accepted; next cycle wr_en=0, wb_valid=0, err_addr=0.
- NUM_REGS=16, ADDR_WIDTH=5, addr=20 -> accepted; next cycle wr_en=0, wb_valid=0, err_addr=1 for exactly one cycle.
- hold=1 for 3 cycles with requesters 0 and 2 valid -> req_ready=0 and rr_ptr unchanged; on hold release, requester 0 is granted first, then requester 2.
- Request accepted at cycle N and rst_n pulled low at cycle N+0.5 -> wr_en=0 and wb_valid=0 immediately; after release, no write occurs without a new grant.
